lut_playback_sequencer: RTL and testbench

//  Steps a synchronous lookup ROM (level table, DEPTH entries) at a programmable pace.

---
 rtl/lut_playback_sequencer.sv | 167 ++++++++++++++++
 tb/tb_lut_playback_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_playback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lut_playback_sequencer
//  Description : Walks a synchronous level-table ROM at a programmable pace.
//                Each entry goes downstream over valid/ready, together with
//                a registered "entry > threshold" comparator flag. Playback
//                is either one-shot or looped.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_playback_sequencer #(
   parameter int DEPTH  = 121,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [DIV_W-1:0]  tick_div,
   input  logic [DATA_W-1:0] threshold,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_above,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_PACE    = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DIV_W-1:0]  C_DIV_ONE   = DIV_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic                loop_q, loop_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                above_q, above_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Next-state and next-output computation for the playback FSM
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      loop_d  = loop_q;
      data_d  = data_q;
      above_d = above_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_FETCH;
               addr_d  = '0;
               cnt_d   = '0;
               // A zero divider is treated as the shortest pace
               div_d   = (tick_div == '0) ? C_DIV_ONE : tick_div;
               loop_d  = loop_en;
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            data_d  = rom_data;
            above_d = (rom_data > threshold);
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (out_ready) begin
               // The accept cycle counts as pace cycle 0
               cnt_d = C_DIV_ONE;
               if (addr_q == C_LAST_ADDR) begin
                  addr_d = '0;
                  if (loop_q) begin
                     state_d = ST_PACE;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_PACE;
               end
            end
         end
         ST_PACE: begin
            if (cnt_q >= div_q) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + C_DIV_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
         end
      endcase

      // Abort overrides everything; the held sample is kept on out_data
      if (stop && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         cnt_d   = '0;
         data_d  = data_q;
         above_d = above_q;
         done_d  = 1'b0;
      end

      valid_d = (state_d == ST_PRESENT);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         div_q   <= C_DIV_ONE;
         cnt_q   <= '0;
         loop_q  <= 1'b0;
         data_q  <= '0;
         above_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         loop_q  <= loop_d;
         data_q  <= data_d;
         above_q <= above_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rom_addr  = addr_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_above = above_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_playback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_playback_sequencer
//  Description : Scoreboard bench for lut_playback_sequencer. Expected
//                samples are queued at launch from the table contents and
//                compared by an independent monitor on every accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_playback_sequencer;

   localparam int DEPTH  = 121;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int DIV_W  = 16;

   logic              clk = 1'b0;
   logic              rst, start, stop, loop_en, out_ready;
   logic [DIV_W-1:0]  tick_div;
   logic [DATA_W-1:0] threshold, rom_data, out_data;
   logic [ADDR_W-1:0] rom_addr;
   logic              out_valid, out_above, busy, done;

   logic [DATA_W-1:0] rom [0:DEPTH-1];

   lut_playback_sequencer #(
      .DEPTH (DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .tick_div (tick_div),
      .threshold(threshold),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_above(out_above),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: one cycle read latency
   always @(posedge clk)
      rom_data <= (int'(rom_addr) < DEPTH) ? rom[rom_addr] : 8'hEE;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          addr;
      logic [7:0]  data;
      bit          above;
      int          gap;   // required cycles since previous accept/start; 0 = unchecked
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         last_acc = 0;
   int         done_cnt = 0;
   logic [7:0] last_data = 8'h00;
   int         ready_mode = 0;  // 0: high, 1: random, 2: low

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Downstream ready driver
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: stability of a stalled sample, scoreboard pop on accept, done timing
   bit         pv = 0, pacc = 0, pab = 0;
   logic [7:0] pd = 0;
   bit         pa = 0;
   always @(negedge clk) begin
      exp_t e;
      if (pv && !pacc && !pab) begin
         chk("valid_held", int'(out_valid), 1);
         chk("data_held", int'(out_data), int'(pd));
         chk("above_held", int'(out_above), int'(pa));
      end
      if (out_valid && out_ready && !stop && !rst) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept actual=%0h required=none", out_data);
         end else begin
            e = sb.pop_front();
            chk("addr", int'(rom_addr), e.addr);
            chk("data", int'(out_data), int'(e.data));
            chk("above", int'(out_above), int'(e.above));
            if (e.gap > 0) chk("spacing", cyc - last_acc, e.gap);
         end
         last_acc  = cyc;
         last_data = out_data;
      end
      if (done) begin
         done_cnt++;
         chk("done_timing", cyc, last_acc + 1);
      end
      pv   = out_valid;
      pacc = out_valid && out_ready;
      pab  = stop || rst;
      pd   = out_data;
      pa   = out_above;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the expected playback, then pulse start for one cycle
   task automatic launch(input int td, input bit lp, input logic [7:0] thr, input int n);
      int   etd;
      int   a;
      exp_t e;
      etd = (td == 0) ? 1 : td;
      for (int i = 0; i < n; i++) begin
         a       = i % DEPTH;
         e.addr  = a;
         e.data  = rom[a];
         e.above = (rom[a] > thr);
         if (ready_mode != 0) e.gap = 0;
         else                 e.gap = (i == 0) ? 3 : etd + 3;
         sb.push_back(e);
      end
      tick_div  = DIV_W'(td);
      loop_en   = lp;
      threshold = thr;
      start     = 1'b1;
      last_acc  = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while (sb.size() != 0 && k < bound) begin
         tick();
         k++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      tick_div = '0; threshold = '0;
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h1D; rom[1] = 8'h13; rom[2] = 8'h22; rom[3] = 8'h09; rom[4] = 8'h02;
      rom[5] = 8'h10; rom[6] = 8'h11; rom[120] = 8'hFF;

      // Reset then idle
      tick(3);
      rst = 1'b0;
      tick(10);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr", int'(rom_addr), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_above", int'(out_above), 0);

      // Full one-shot run, tick_div=6, threshold 0x10
      launch(6, 1'b0, 8'h10, DEPTH);
      drain(DEPTH * 9 + 50);
      tick(3);
      chk("oneshot_done_count", done_cnt, 1);
      chk("oneshot_busy", int'(busy), 0);
      chk("oneshot_addr", int'(rom_addr), 0);

      // Stall in PRESENT, then random backpressure through a full one-shot
      ready_mode = 2;
      launch(2, 1'b0, 8'h80, DEPTH);
      k = 0;
      while (!out_valid && k < 10) begin tick(); k++; end
      chk("stall_reach_present", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_addr", int'(rom_addr), 0);
      end
      ready_mode = 1;
      drain(DEPTH * 16 + 50);
      ready_mode = 0;
      tick(3);
      chk("stall_done_count", done_cnt, 2);

      // Looped run with tick_div=0 across the wrap, then stop in PACE
      launch(0, 1'b1, 8'h40, DEPTH + 4);
      drain((DEPTH + 4) * 4 + 50);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_valid", int'(out_valid), 0);
      chk("stop_done", int'(done), 0);
      chk("stop_addr", int'(rom_addr), 0);
      chk("stop_data_kept", int'(out_data), int'(last_data));
      tick(3);
      chk("loop_no_done", done_cnt, 2);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", int'(busy), 0);
      tick(2);
      chk("startstop_busy_later", int'(busy), 0);
      chk("startstop_valid", int'(out_valid), 0);

      // start while busy is ignored, then reset while pacing
      launch(6, 1'b1, 8'h10, 30);
      tick(12);
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (sb.size() > 20 && k < 200) begin tick(); k++; end
      k = 0;
      while (cyc != last_acc + 2 && k < 20) begin tick(); k++; end
      chk("reach_pace", cyc - last_acc, 2);
      rst = 1'b1;
      tick();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_addr", int'(rom_addr), 0);
      chk("midrst_data", int'(out_data), 0);
      chk("midrst_above", int'(out_above), 0);
      rst = 1'b0;
      sb.delete();
      tick(4);
      chk("post_rst_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
